// File: rtl/exmem_stage_fwd.sv
// ---------------------------------------------------------------------------
// exmem_stage_fwd
//   EX/MEM pipeline register for the MIPS pipeline. It carries the EXE result
//   and MEM controls into the MEM stage, and adds the following:
//     - a valid bit; a bubble never carries memory or writeback side effects
//     - priority-ordered forwarding of store data, matched on register number
//     - refresh of held store data while the stage is stalled
//     - saturating stall and flush performance counters
//
// Ports
//   CLOCK, RESET          clock; synchronous active-high reset
//   STALL, FLUSH          hold stage / insert bubble (FLUSH wins)
//   CNT_CLEAR             synchronous clear of both counters
//   Valid_IN              incoming instruction is real (0 = bubble)
//   MemWriteData_IN       store data from ID/EXE
//   StoreSrcReg_IN        source register (rt) of the store data
//   MemControl_IN         MEM control field
//   MemRead_IN            load
//   MemWrite_IN           store
//   ALUResult_IN          ALU result / address
//   WriteRegister_IN      destination register
//   WriteEnable_IN        writeback enable
//   Fwd_Valid/Reg/Data    forwarding channels, packed; channel 0 has highest
//                         priority
//   *_OUT                 registered stage contents
//   StallCount_OUT        saturating count of stall cycles
//   FlushCount_OUT        saturating count of flush cycles
// ---------------------------------------------------------------------------
module exmem_stage_fwd #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 6,
  parameter int NUM_FWD  = 2,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      STALL,
  input  logic                      FLUSH,
  input  logic                      CNT_CLEAR,
  input  logic                      Valid_IN,
  input  logic [DATA_W-1:0]         MemWriteData_IN,
  input  logic [REG_W-1:0]          StoreSrcReg_IN,
  input  logic [CTRL_W-1:0]         MemControl_IN,
  input  logic                      MemRead_IN,
  input  logic                      MemWrite_IN,
  input  logic [DATA_W-1:0]         ALUResult_IN,
  input  logic [REG_W-1:0]          WriteRegister_IN,
  input  logic                      WriteEnable_IN,
  input  logic [NUM_FWD-1:0]        Fwd_Valid,
  input  logic [NUM_FWD*REG_W-1:0]  Fwd_Reg,
  input  logic [NUM_FWD*DATA_W-1:0] Fwd_Data,
  output logic                      Valid_OUT,
  output logic [DATA_W-1:0]         MemWriteData_OUT,
  output logic [CTRL_W-1:0]         MemControl_OUT,
  output logic                      MemRead_OUT,
  output logic                      MemWrite_OUT,
  output logic [DATA_W-1:0]         ALUResult_OUT,
  output logic [REG_W-1:0]          WriteRegister_OUT,
  output logic                      WriteEnable_OUT,
  output logic [CNT_W-1:0]          StallCount_OUT,
  output logic [CNT_W-1:0]          FlushCount_OUT
);

  // Source register of the store currently held in the stage; needed so a
  // stalled store can still pick up a late-arriving forward.
  logic [REG_W-1:0]  storeSrcReg;

  logic              inFwdHit;
  logic [DATA_W-1:0] inFwdData;
  logic              heldFwdHit;
  logic [DATA_W-1:0] heldFwdData;
  logic              inIsZero;
  logic              heldIsZero;

  // With a hardwired register 0, a write "to r0" must never be forwarded.
  assign inIsZero   = (ZERO_REG != 0) && (StoreSrcReg_IN == '0);
  assign heldIsZero = (ZERO_REG != 0) && (storeSrcReg == '0);

  // Two independent lookups: one for the incoming store, one for the held
  // store. The first matching channel (lowest index) wins.
  always_comb begin
    inFwdHit    = 1'b0;
    inFwdData   = '0;
    heldFwdHit  = 1'b0;
    heldFwdData = '0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!inFwdHit && !inIsZero && Fwd_Valid[i] &&
          (Fwd_Reg[i*REG_W +: REG_W] == StoreSrcReg_IN)) begin
        inFwdHit  = 1'b1;
        inFwdData = Fwd_Data[i*DATA_W +: DATA_W];
      end
      if (!heldFwdHit && !heldIsZero && Fwd_Valid[i] &&
          (Fwd_Reg[i*REG_W +: REG_W] == storeSrcReg)) begin
        heldFwdHit  = 1'b1;
        heldFwdData = Fwd_Data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stage payload.
  always_ff @(posedge CLOCK) begin
    if (RESET || FLUSH) begin
      Valid_OUT         <= 1'b0;
      MemWriteData_OUT  <= '0;
      MemControl_OUT    <= '0;
      MemRead_OUT       <= 1'b0;
      MemWrite_OUT      <= 1'b0;
      ALUResult_OUT     <= '0;
      WriteRegister_OUT <= '0;
      WriteEnable_OUT   <= 1'b0;
      storeSrcReg       <= '0;
    end else if (STALL) begin
      // Everything holds except store data of a real, held store, which
      // tracks the producer if it has only now become forwardable.
      if (Valid_OUT && MemWrite_OUT && heldFwdHit) begin
        MemWriteData_OUT <= heldFwdData;
      end
    end else begin
      Valid_OUT         <= Valid_IN;
      MemWriteData_OUT  <= inFwdHit ? inFwdData : MemWriteData_IN;
      MemControl_OUT    <= MemControl_IN;
      // Bubbles keep their data fields but lose every side-effect control.
      MemRead_OUT       <= MemRead_IN && Valid_IN;
      MemWrite_OUT      <= MemWrite_IN && Valid_IN;
      ALUResult_OUT     <= ALUResult_IN;
      WriteRegister_OUT <= WriteRegister_IN;
      WriteEnable_OUT   <= WriteEnable_IN && Valid_IN;
      storeSrcReg       <= StoreSrcReg_IN;
    end
  end

  // Performance counters; saturate instead of wrapping.
  always_ff @(posedge CLOCK) begin
    if (RESET || CNT_CLEAR) begin
      StallCount_OUT <= '0;
      FlushCount_OUT <= '0;
    end else if (FLUSH) begin
      if (FlushCount_OUT != '1) begin
        FlushCount_OUT <= FlushCount_OUT + CNT_W'(1);
      end
    end else if (STALL) begin
      if (StallCount_OUT != '1) begin
        StallCount_OUT <= StallCount_OUT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_exmem_stage_fwd.sv
module tb_exmem_stage_fwd;

  logic        CLOCK;
  logic        RESET;
  logic        STALL;
  logic        FLUSH;
  logic        CNT_CLEAR;
  logic        Valid_IN;
  logic [31:0] MemWriteData_IN;
  logic [4:0]  StoreSrcReg_IN;
  logic [5:0]  MemControl_IN;
  logic        MemRead_IN;
  logic        MemWrite_IN;
  logic [31:0] ALUResult_IN;
  logic [4:0]  WriteRegister_IN;
  logic        WriteEnable_IN;
  logic [1:0]  Fwd_Valid;
  logic [9:0]  Fwd_Reg;
  logic [63:0] Fwd_Data;
  logic        Valid_OUT;
  logic [31:0] MemWriteData_OUT;
  logic [5:0]  MemControl_OUT;
  logic        MemRead_OUT;
  logic        MemWrite_OUT;
  logic [31:0] ALUResult_OUT;
  logic [4:0]  WriteRegister_OUT;
  logic        WriteEnable_OUT;
  logic [3:0]  StallCount_OUT;
  logic [3:0]  FlushCount_OUT;

  exmem_stage_fwd #(
    .DATA_W(32), .REG_W(5), .CTRL_W(6), .NUM_FWD(2), .CNT_W(4), .ZERO_REG(1)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH),
    .CNT_CLEAR(CNT_CLEAR), .Valid_IN(Valid_IN),
    .MemWriteData_IN(MemWriteData_IN), .StoreSrcReg_IN(StoreSrcReg_IN),
    .MemControl_IN(MemControl_IN), .MemRead_IN(MemRead_IN),
    .MemWrite_IN(MemWrite_IN), .ALUResult_IN(ALUResult_IN),
    .WriteRegister_IN(WriteRegister_IN), .WriteEnable_IN(WriteEnable_IN),
    .Fwd_Valid(Fwd_Valid), .Fwd_Reg(Fwd_Reg), .Fwd_Data(Fwd_Data),
    .Valid_OUT(Valid_OUT), .MemWriteData_OUT(MemWriteData_OUT),
    .MemControl_OUT(MemControl_OUT), .MemRead_OUT(MemRead_OUT),
    .MemWrite_OUT(MemWrite_OUT), .ALUResult_OUT(ALUResult_OUT),
    .WriteRegister_OUT(WriteRegister_OUT), .WriteEnable_OUT(WriteEnable_OUT),
    .StallCount_OUT(StallCount_OUT), .FlushCount_OUT(FlushCount_OUT)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] mwd;
    logic [5:0]  mctl;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        we;
    logic [3:0]  sc;
    logic [3:0]  fc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every rising edge the stage presents a new state; compare it
  // with the oldest expectation queued by the stimulus.
  always @(posedge CLOCK) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("Valid_OUT",         32'(Valid_OUT),         32'(x.valid));
      chk("MemWriteData_OUT",  MemWriteData_OUT,       x.mwd);
      chk("MemControl_OUT",    32'(MemControl_OUT),    32'(x.mctl));
      chk("MemRead_OUT",       32'(MemRead_OUT),       32'(x.mr));
      chk("MemWrite_OUT",      32'(MemWrite_OUT),      32'(x.mw));
      chk("ALUResult_OUT",     ALUResult_OUT,          x.alu);
      chk("WriteRegister_OUT", 32'(WriteRegister_OUT), 32'(x.wr));
      chk("WriteEnable_OUT",   32'(WriteEnable_OUT),   32'(x.we));
      chk("StallCount_OUT",    32'(StallCount_OUT),    32'(x.sc));
      chk("FlushCount_OUT",    32'(FlushCount_OUT),    32'(x.fc));
    end
  end

  task automatic clrIn();
    STALL = 0; FLUSH = 0; CNT_CLEAR = 0; Valid_IN = 0;
    MemWriteData_IN = '0; StoreSrcReg_IN = '0; MemControl_IN = '0;
    MemRead_IN = 0; MemWrite_IN = 0; ALUResult_IN = '0;
    WriteRegister_IN = '0; WriteEnable_IN = 0;
    Fwd_Valid = '0; Fwd_Reg = '0; Fwd_Data = '0;
  endtask

  task automatic setFwd(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                        input logic [31:0] d0, input logic [31:0] d1);
    Fwd_Valid = v;
    Fwd_Reg   = {r1, r0};
    Fwd_Data  = {d1, d0};
  endtask

  // Queue the expected post-edge state, then let the edge happen.
  task automatic cyc();
    q.push_back(e);
    @(negedge CLOCK);
  endtask

  initial begin
    clrIn();
    e = '0;

    // Reset with every input nonzero.
    RESET = 1; STALL = 1; FLUSH = 1; CNT_CLEAR = 1; Valid_IN = 1;
    MemWriteData_IN = 32'hFFFF_FFFF; StoreSrcReg_IN = 5'd9; MemControl_IN = 6'h3F;
    MemRead_IN = 1; MemWrite_IN = 1; ALUResult_IN = 32'h1234_5678;
    WriteRegister_IN = 5'd31; WriteEnable_IN = 1;
    setFwd(2'b11, 5'd9, 5'd9, 32'h1111, 32'h2222);
    cyc(); cyc();

    // First load after reset.
    clrIn(); RESET = 0;
    Valid_IN = 1; ALUResult_IN = 32'h1000; WriteRegister_IN = 5'd8; WriteEnable_IN = 1;
    e = '0; e.valid = 1; e.alu = 32'h1000; e.wr = 5'd8; e.we = 1;
    cyc();

    // Forward priority on load.
    clrIn(); Valid_IN = 1; MemWrite_IN = 1; MemControl_IN = 6'h15;
    ALUResult_IN = 32'h2000; StoreSrcReg_IN = 5'd9; MemWriteData_IN = 32'hAAAA;
    setFwd(2'b11, 5'd9, 5'd9, 32'h1111, 32'h2222);
    e = '0; e.valid = 1; e.mw = 1; e.mctl = 6'h15; e.alu = 32'h2000; e.mwd = 32'h1111;
    cyc();
    Fwd_Valid = 2'b10; e.mwd = 32'h2222;
    cyc();
    setFwd(2'b11, 5'd3, 5'd9, 32'h1111, 32'h2222); e.mwd = 32'h2222;
    cyc();
    StoreSrcReg_IN = 5'd0; setFwd(2'b11, 5'd0, 5'd0, 32'h1111, 32'h2222); e.mwd = 32'hAAAA;
    cyc();

    // Held store refreshed by a forward during a stall.
    clrIn(); Valid_IN = 1; MemWrite_IN = 1; MemControl_IN = 6'h2A;
    ALUResult_IN = 32'h3000; StoreSrcReg_IN = 5'd10; MemWriteData_IN = 32'h5;
    e = '0; e.valid = 1; e.mw = 1; e.mctl = 6'h2A; e.alu = 32'h3000; e.mwd = 32'h5;
    cyc();
    clrIn(); STALL = 1; ALUResult_IN = 32'hDEAD; WriteEnable_IN = 1; Valid_IN = 1;
    MemWriteData_IN = 32'h99; StoreSrcReg_IN = 5'd10;
    e.sc = 1;
    cyc();
    setFwd(2'b10, 5'd3, 5'd10, 32'h88, 32'h77); e.mwd = 32'h77; e.sc = 2;
    cyc();
    setFwd(2'b00, 5'd0, 5'd0, 32'h0, 32'h0); e.sc = 3;
    cyc();

    // Flush together with stall.
    FLUSH = 1;
    e.valid = 0; e.mw = 0; e.mctl = 0; e.alu = 0; e.mwd = 0; e.fc = 1;
    cyc();

    // Bubble squash on load.
    clrIn(); Valid_IN = 0; MemWrite_IN = 1; MemRead_IN = 1; WriteEnable_IN = 1;
    ALUResult_IN = 32'h44; WriteRegister_IN = 5'd7; MemControl_IN = 6'h3;
    MemWriteData_IN = 32'h99; StoreSrcReg_IN = 5'd4;
    e.alu = 32'h44; e.wr = 5'd7; e.mctl = 6'h3; e.mwd = 32'h99;
    cyc();
    // A held bubble is never refreshed.
    STALL = 1; setFwd(2'b01, 5'd4, 5'd0, 32'hBEEF, 32'h0); e.sc = 4;
    cyc();

    // Stall counter saturation, then clear winning over increment.
    clrIn(); STALL = 1;
    for (int i = 0; i < 20; i++) begin
      if (e.sc != 4'hF) e.sc = e.sc + 4'd1;
      cyc();
    end
    CNT_CLEAR = 1; e.sc = 0; e.fc = 0;
    cyc();
    CNT_CLEAR = 0; STALL = 0; FLUSH = 1;
    e.fc = 1; e.alu = 0; e.wr = 0; e.mctl = 0; e.mwd = 0;
    cyc();

    // Reset in the middle of a stall, then resume loading.
    clrIn(); Valid_IN = 1; ALUResult_IN = 32'h55; WriteRegister_IN = 5'd2; WriteEnable_IN = 1;
    e.valid = 1; e.alu = 32'h55; e.wr = 5'd2; e.we = 1;
    cyc();
    RESET = 1; STALL = 1; e = '0;
    cyc();
    RESET = 0; STALL = 0; ALUResult_IN = 32'h66; WriteRegister_IN = 5'd3;
    e.valid = 1; e.alu = 32'h66; e.wr = 5'd3; e.we = 1;
    cyc();

    clrIn();
    @(posedge CLOCK);
    #3;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exmem_stage_fwd.md
Name: exmem_stage_fwd

Overview:
Parametrised EX/MEM pipeline register for the MIPS pipeline, the successor to the fixed 32-bit EX/MEM latch. It adds:
- an explicit valid bit, with bubble squashing of side-effect controls;
- NUM_FWD priority-ordered, register-matched forwarding channels for store data;
- refresh of held store data while stalled;
- saturating stall and flush performance counters.

It sits between the EXE stage (and hazard unit) and the MEM stage.

Parameters:
DATA_W, 32, width of ALU result and store data
REG_W, 5, register-address width
CTRL_W, 6, width of the MEM control field
NUM_FWD, 2, number of forwarding channels; index 0 has highest priority
CNT_W, 16, width of each performance counter
ZERO_REG, 1, 1 = register 0 is hardwired and never matches a forward

Ports:
CLOCK  in  1  system clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
STALL  in  1  hold stage contents
FLUSH  in  1  insert bubble; priority over STALL
CNT_CLEAR  in  1  synchronous clear of both counters
Valid_IN  in  1  incoming instruction is real (0 = bubble)
MemWriteData_IN  in  DATA_W  store data from ID/EXE
StoreSrcReg_IN  in  REG_W  source register (rt) of the store data
MemControl_IN  in  CTRL_W  MEM control field
MemRead_IN  in  1  load
MemWrite_IN  in  1  store
ALUResult_IN  in  DATA_W  ALU result / address
WriteRegister_IN  in  REG_W  destination register
WriteEnable_IN  in  1  register writeback enable
Fwd_Valid  in  NUM_FWD  per-channel forward valid
Fwd_Reg  in  NUM_FWD*REG_W  per-channel destination register; channel i at [i*REG_W +: REG_W]
Fwd_Data  in  NUM_FWD*DATA_W  per-channel data; channel i at [i*DATA_W +: DATA_W]
Valid_OUT  out  1  stage holds a real instruction
MemWriteData_OUT  out  DATA_W  registered store data
MemControl_OUT  out  CTRL_W  registered
MemRead_OUT  out  1  registered
MemWrite_OUT  out  1  registered
ALUResult_OUT  out  DATA_W  registered
WriteRegister_OUT  out  REG_W  registered
WriteEnable_OUT  out  1  registered
StallCount_OUT  out  CNT_W  saturating count of stall cycles
FlushCount_OUT  out  CNT_W  saturating count of flush cycles

Behaviour:
- All outputs are driven directly from registers; latency is 1 cycle from inputs to outputs.
- Forward match for a register r on channel i: Fwd_Valid[i]=1 and Fwd_Reg[i]==r, and not (ZERO_REG=1 and r==0).
- Forward select: the lowest-index matching channel wins; if no channel matches, there is no forward.
- Per rising edge, the payload is updated by the first matching case, in this priority order:
  1. RESET=1: every output register, including the internal held store-source register and both counters, is set to 0.
  2. FLUSH=1 (STALL ignored): Valid and all payload fields are set to 0.
  3. STALL=1: all fields hold, with one exception. If Valid_OUT=1, MemWrite_OUT=1 and the held StoreSrcReg matches a forward, MemWriteData is replaced with that channel's data. This refresh is new behaviour.
  4. Otherwise (load): all fields load from *_IN. MemWriteData loads the forwarded data if StoreSrcReg_IN matches, else MemWriteData_IN. StoreSrcReg_IN is captured internally.
- Bubble squash on load: when Valid_IN=0, MemRead, MemWrite and WriteEnable load as 0. Data fields still load.
- Counters, when RESET=0:
  - CNT_CLEAR=1 sets both counters to 0. Clear wins over any simultaneous increment.
  - Otherwise StallCount increments in cycles with STALL=1 and FLUSH=0.
  - Otherwise FlushCount increments in cycles with FLUSH=1.
  - Both counters saturate at 2^CNT_W-1; they never wrap.
- A reset asserted mid-stall or mid-flush clears everything on that edge; the stage resumes loading on the first edge after RESET deasserts.
- The block is fully synchronous, contains no latches and has no $display side effects.

Test Plan:
1. RESET=1 for 2 cycles while all inputs are driven nonzero -> every output is 0. Then load Valid_IN=1, ALUResult_IN=0x1000, WriteRegister_IN=8, WriteEnable_IN=1 -> values appear one cycle later with Valid_OUT=1.
2. Load a store with StoreSrcReg_IN=9, MemWriteData_IN=0xAAAA. Fwd ch0 (reg 9, 0x1111) and ch1 (reg 9, 0x2222) are both valid -> MemWriteData_OUT=0x1111. Disable ch0 -> next load gives 0x2222. StoreSrcReg_IN=0 with ZERO_REG=1 and both channels at reg 0 -> 0xAAAA.
3. Hold a store (src 10, data 0x5) with STALL=1 for 3 cycles. In cycle 2, ch1 forwards reg 10 = 0x77 -> MemWriteData_OUT=0x77 and every other field is unchanged. StallCount_OUT=3.
4. FLUSH=1 and STALL=1 together -> Valid_OUT, MemWrite_OUT and WriteEnable_OUT are 0; FlushCount_OUT increments by 1 and StallCount_OUT is unchanged.
5. Valid_IN=0 with MemWrite_IN=1, MemRead_IN=1, WriteEnable_IN=1, ALUResult_IN=0x44 -> control outputs are 0 and ALUResult_OUT=0x44.
6. With CNT_W=4, hold STALL for 20 cycles -> StallCount_OUT saturates at 15. CNT_CLEAR=1 asserted together with STALL -> 0 on the next edge.
